// File: rtl/note_stabilizer.sv
// note_stabilizer: debounces detector frames into a stable note code; NOTE_STAB_HYST_EN enables release hysteresis.
module note_stabilizer #(
    parameter int MAG_WIDTH      = 16,
    parameter int MAG_THRESH     = 1000,
    parameter int REL_THRESH     = 600,
    parameter int HOLD_COUNT     = 4,
    parameter int TIMEOUT_CYCLES = 34816000
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 valid_in,
    input  logic [5:0]           note_in,
    input  logic [MAG_WIDTH-1:0] mag_in,
    output logic [5:0]           note_out,
    output logic                 change_out,
    output logic                 locked_out
);
    localparam logic [7:0]  HOLD = 8'(HOLD_COUNT);
    localparam logic [25:0] TMO  = 26'(TIMEOUT_CYCLES);

    if (REL_THRESH > MAG_THRESH || HOLD_COUNT < 1 || HOLD_COUNT > 255) begin : g_bad_cfg
        $error("note_stabilizer: illegal REL_THRESH or HOLD_COUNT");
    end

    logic [5:0]           cand_note, cand_note_d, note_d, e;
    logic [7:0]           cand_cnt, cand_cnt_d;
    logic [25:0]          idle_cnt, idle_d;
    logic [MAG_WIDTH-1:0] thr;
    logic                 commit, timeout, change_d;

`ifdef NOTE_STAB_HYST_EN
    // a sustained note keeps the lower release threshold while it decays
    assign thr = (note_out != 6'd0 && note_in == note_out) ? MAG_WIDTH'(REL_THRESH) : MAG_WIDTH'(MAG_THRESH);
`else
    assign thr = MAG_WIDTH'(MAG_THRESH);
`endif

    always_comb begin
        e           = mag_in < thr ? 6'd0 : note_in;
        timeout     = !valid_in && idle_cnt == TMO - 26'd1;
        cand_note_d = valid_in ? e : (timeout ? 6'd0 : cand_note);
        cand_cnt_d  = valid_in ? (e == cand_note ? (cand_cnt >= HOLD ? HOLD : cand_cnt + 8'd1) : 8'd1)
                               : (timeout ? 8'd0 : cand_cnt);
        commit      = valid_in && cand_cnt_d == HOLD && e != note_out;
        note_d      = commit ? e : (timeout ? 6'd0 : note_out);
        change_d    = commit || (timeout && note_out != 6'd0);
        idle_d      = valid_in ? 26'd0 : (idle_cnt == TMO ? TMO : idle_cnt + 26'd1);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            note_out   <= '0;
            change_out <= 1'b0;
            locked_out <= 1'b0;
            cand_note  <= '0;
            cand_cnt   <= '0;
            idle_cnt   <= '0;
        end else begin
            note_out   <= note_d;
            change_out <= change_d;
            locked_out <= cand_cnt == HOLD && cand_note == note_out;
            cand_note  <= cand_note_d;
            cand_cnt   <= cand_cnt_d;
            idle_cnt   <= idle_d;
        end
    end
endmodule

// File: tb/tb_note_stabilizer.sv
// tb_note_stabilizer: directed and random frames checked against a frame-history reference model.
module tb_note_stabilizer;
    localparam int HOLD = 4;
    localparam int TO   = 100;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        valid_in = 1'b0;
    logic [5:0]  note_in = '0;
    logic [15:0] mag_in = '0;
    logic [5:0]  note_out;
    logic        change_out, locked_out;

    note_stabilizer #(
        .MAG_WIDTH(16), .MAG_THRESH(1000), .REL_THRESH(600),
        .HOLD_COUNT(HOLD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .note_in(note_in),
        .mag_in(mag_in), .note_out(note_out), .change_out(change_out), .locked_out(locked_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int passes = 0;
    int m_out = 0;
    int m_change = 0;
    int m_locked = 0;
    int m_idle = 0;
    int hist[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    function automatic bit last_all(input int val);
        if (hist.size() < HOLD) return 1'b0;
        for (int i = hist.size() - HOLD; i < hist.size(); i++)
            if (hist[i] != val) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_out = 0; m_change = 0; m_locked = 0; m_idle = 0;
        hist.delete();
    endtask

    // one clock edge of the reference behaviour, using pre-edge state
    task automatic model_edge(input bit v, input int n, input int m);
        int thr, e, lock_next;
        lock_next = last_all(m_out);
        m_change = 0;
        if (v) begin
`ifdef NOTE_STAB_HYST_EN
            thr = (m_out != 0 && n == m_out) ? 600 : 1000;
`else
            thr = 1000;
`endif
            e = (m < thr) ? 0 : n;
            m_idle = 0;
            hist.push_back(e);
            if (hist.size() > HOLD) void'(hist.pop_front());
            if (last_all(e) && e != m_out) begin
                m_out = e;
                m_change = 1;
            end
        end else if (m_idle < TO) begin
            m_idle++;
            if (m_idle == TO) begin
                m_change = (m_out != 0);
                m_out = 0;
                hist.delete();
            end
        end
        m_locked = lock_next;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".note"}, 32'(note_out), 32'(m_out));
        check({tag, ".change"}, 32'(change_out), 32'(m_change));
        check({tag, ".locked"}, 32'(locked_out), 32'(m_locked));
    endtask

    task automatic step(input bit v, input int n, input int m, input string tag);
        valid_in = v;
        note_in = 6'(n);
        mag_in = 16'(m);
        @(posedge clk_in);
        model_edge(v, n, m);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) step(1'b0, 0, 0, tag);
    endtask

    task automatic frames(input int count, input int n, input int m, input string tag);
        for (int i = 0; i < count; i++) step(1'b1, n, m, tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_in = 1'b1;
        #1 model_reset();
        check_all(tag);
        #2 rst_in = 1'b0;
    endtask

    initial begin
        // 1: reset and commit with spaced frames
        repeat (2) @(posedge clk_in);
        #1 model_reset();
        check_all("reset");
        check("reset.note_const", 32'(note_out), 32'd0);
        rst_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 12, 2000, "t1_frame");
            check("t1.note_held_zero", 32'(note_out), 32'd0);
            idle(2, "t1_gap");
        end
        step(1'b1, 12, 2000, "t1_commit");
        check("t1.note_12", 32'(note_out), 32'd12);
        check("t1.change_pulse", 32'(change_out), 32'd1);
        step(1'b0, 0, 0, "t1_after");
        check("t1.locked", 32'(locked_out), 32'd1);
        check("t1.pulse_gone", 32'(change_out), 32'd0);

        // 2: glitch rejection
        step(1'b1, 12, 2000, "t2"); step(1'b1, 12, 2000, "t2");
        step(1'b1, 19, 2000, "t2");
        step(1'b1, 12, 2000, "t2"); step(1'b1, 12, 2000, "t2");
        check("t2.note_12", 32'(note_out), 32'd12);

        // 3: silence below onset threshold
        frames(4, 12, 2000, "t3_lock");
        frames(4, 12, 800, "t3_soft");
`ifdef NOTE_STAB_HYST_EN
        check("t3.hyst_hold", 32'(note_out), 32'd12);
        frames(4, 12, 500, "t3_release");
`endif
        check("t3.rest", 32'(note_out), 32'd0);

        // 4: timeout, then valid frame on the timeout edge
        frames(4, 12, 2000, "t4_lock");
        idle(TO - 1, "t4_idle");
        check("t4.before_timeout", 32'(note_out), 32'd12);
        step(1'b0, 0, 0, "t4_timeout");
        check("t4.timeout_note", 32'(note_out), 32'd0);
        check("t4.timeout_pulse", 32'(change_out), 32'd1);
        idle(20, "t4_after");
        frames(4, 12, 2000, "t4_relock");
        idle(TO - 1, "t4_idle2");
        step(1'b1, 12, 2000, "t4_race");
        check("t4.race_note", 32'(note_out), 32'd12);
        idle(3, "t4_post");

        // 5: async reset mid-count
        frames(2, 30, 2000, "t5_pre");
        async_reset("t5_reset");
        check("t5.reset_note", 32'(note_out), 32'd0);
        frames(2, 30, 2000, "t5_post");
        check("t5.no_commit", 32'(note_out), 32'd0);

        // 6: same-note recommit
        frames(4, 12, 2000, "t6_lock");
        idle(1, "t6");
        frames(4, 12, 2000, "t6_again");
        check("t6.locked", 32'(locked_out), 32'd1);

        // random frames with occasional long silences and a reset
        for (int r = 0; r < 600; r++) begin
            int pick;
            pick = $urandom_range(0, 3);
            step($urandom_range(0, 3) != 0, (pick == 0) ? 0 : (pick == 1) ? 5 : (pick == 2) ? 12 : 19,
                 $urandom_range(0, 2000), "rand");
            if (r % 150 == 149) idle($urandom_range(90, 110), "rand_idle");
            if (r == 333) async_reset("rand_reset");
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/note_stabilizer.md
Name: note_stabilizer

Overview:
- Sits directly upstream of the eighth-note recorder and drives its 6-bit note input.
- Takes raw per-frame note indices and magnitudes from the pitch detector, rejects low-energy frames as rests, and debounces transient misdetections.
- Holds a clean, glitch-free note code that the recorder can sample at any clock edge.
- Note code 0 means rest; codes 1..63 are pitches.

Parameters:
- MAG_WIDTH, 16, width of the detector magnitude input.
- MAG_THRESH, 1000, onset magnitude; a valid frame with mag_in < MAG_THRESH counts as rest.
- REL_THRESH, 600, release magnitude; used only when NOTE_STAB_HYST_EN is defined; must be <= MAG_THRESH.
- HOLD_COUNT, 4, number of consecutive matching valid frames needed to commit a note; legal range 1..255.
- TIMEOUT_CYCLES, 34816000, number of clock cycles with no valid_in after which the output is forced to rest; counter is 26 bits.

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, asynchronous active-high reset.
- valid_in, input, 1, single-cycle strobe; note_in and mag_in are valid this cycle.
- note_in, input, 6, raw detected note index; 0 means rest.
- mag_in, input, MAG_WIDTH, peak magnitude of the detected note.
- note_out, output, 6, committed stable note; feeds the recorder.
- change_out, output, 1, one-cycle pulse on the cycle note_out takes a new value.
- locked_out, output, 1, high while the candidate matches note_out with a full hold count.

Behaviour:
- Reset is asynchronous. While rst_in is high, these are all 0: note_out, change_out, locked_out, cand_note, cand_cnt (8 bits), idle_cnt (26 bits). Reset mid-stream discards the candidate. No commit occurs on the first edge after release.
- Effective note e, evaluated only when valid_in=1: e = 0 if mag_in < thr, otherwise note_in. thr is MAG_THRESH, or REL_THRESH when hysteresis applies (see Optional Feature). Unsigned compare.
- Candidate tracking on a valid frame:
  - e == cand_note: cand_cnt <= min(cand_cnt+1, HOLD_COUNT).
  - otherwise: cand_note <= e, cand_cnt <= 1.
- Commit:
  - Condition: the clock edge sampling a valid frame that makes the new cand_cnt equal HOLD_COUNT, with e != note_out.
  - On that edge: note_out <= e and change_out <= 1.
  - change_out is 0 on every other cycle.
  - Latency: note_out changes on the edge sampling the HOLD_COUNT-th matching frame (visible the following cycle).
  - If e == note_out at commit, there is no change pulse.
  - HOLD_COUNT=1: every valid frame with e != note_out commits immediately.
- A single mismatched frame restarts the count. Only strictly consecutive valid frames accumulate. Cycles with valid_in=0 neither break nor advance the count.
- Timeout:
  - idle_cnt clears to 0 on any valid_in cycle; otherwise it increments, saturating at TIMEOUT_CYCLES.
  - When idle_cnt is TIMEOUT_CYCLES-1 and valid_in=0, on that edge: note_out <= 0 (with change_out=1 if note_out was nonzero), cand_note <= 0, cand_cnt <= 0.
  - The timeout fires once per idle period.
  - If valid_in arrives on that same edge, valid_in has priority: there is no timeout, and the frame is processed normally.
- locked_out is registered: 1 when cand_cnt == HOLD_COUNT and cand_note == note_out, else 0.
- note_out never changes except on a commit or a timeout edge. The downstream recorder may sample it unsynchronised.

Optional Feature:
- Macro: NOTE_STAB_HYST_EN.
- Defined:
  - While note_out != 0 and note_in == note_out, a frame uses thr = REL_THRESH.
  - All other frames use MAG_THRESH.
  - Effect: a decaying sustained note is held until its magnitude falls below REL_THRESH.
- Undefined: thr = MAG_THRESH always; REL_THRESH is ignored; no extra logic is synthesised.

Test Plan (HOLD_COUNT=4, MAG_THRESH=1000, REL_THRESH=600, TIMEOUT_CYCLES=100):
1. Reset and commit: reset, then 4 valid frames note_in=12, mag=2000, spaced 3 cycles apart -> note_out=0 through the 3rd frame; note_out=12 and a single change_out pulse on the edge of the 4th frame; locked_out=1 the cycle after.
2. Glitch rejection: locked on 12, then frames 12,12,19,12,12 -> note_out stays 12; change_out stays 0; no commit of 19.
3. Silence: locked on 12, then 4 frames note_in=12, mag=800 -> note_out=0 with change_out pulse on the 4th. Same stimulus with NOTE_STAB_HYST_EN defined -> note_out stays 12. With the macro, mag=500 x4 -> note_out=0.
4. Timeout: locked on 12, then no valid_in for 100 cycles -> note_out=0 and change_out=1 exactly once on the 100th idle edge. Repeat with valid_in (12, mag 2000) on that exact edge -> no timeout; note_out stays 12.
5. Async reset mid-count: 2 frames of 30, assert rst_in between clock edges -> outputs go 0 immediately. After release, 2 more frames of 30 -> no commit (count restarted).
6. Same-note recommit: locked on 12, then 4 frames of 12 -> no change_out pulse; locked_out remains 1.
